// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the RV32I instruction encoder/loader: format codes,
// base opcodes, immediate range limits and small legality helpers.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed SHAMT_MAX = 31;
  localparam int signed BIMM_MIN  = -4096;
  localparam int signed BIMM_MAX  = 4094;
  localparam int signed JIMM_MIN  = -(1 << 20);
  localparam int signed JIMM_MAX  = (1 << 20) - 2;

  function automatic logic is_shift(input logic [2:0] func3);
    return (func3 == 3'b001) || (func3 == 3'b101);
  endfunction

  function automatic logic in_range(input logic [31:0] v, input int signed lo,
                                    input int signed hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I field packer: the exact inverse of immediate generation,
// plus a legality flag for out-of-range or misaligned immediates.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  func3_i,
  input  logic [6:0]  func7_i,
  input  logic [31:0] immd_i,
  output logic [31:0] instr_o,
  output logic        legal_o
);

  always_comb begin
    instr_o = '0;
    legal_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        instr_o = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      FMT_I: begin
        // Shift-immediates carry func7 in the upper bits and a 5-bit shamt.
        if (is_shift(func3_i)) begin
          instr_o = {func7_i, immd_i[4:0], rs1_i, func3_i, rd_i, opcode_i};
          legal_o = in_range(immd_i, 0, SHAMT_MAX);
        end else begin
          instr_o = {immd_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
          legal_o = in_range(immd_i, IMM12_MIN, IMM12_MAX);
        end
      end
      FMT_S: begin
        instr_o = {immd_i[11:5], rs2_i, rs1_i, func3_i, immd_i[4:0], opcode_i};
        legal_o = in_range(immd_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        instr_o = {immd_i[12], immd_i[10:5], rs2_i, rs1_i, func3_i,
                   immd_i[4:1], immd_i[11], opcode_i};
        legal_o = in_range(immd_i, BIMM_MIN, BIMM_MAX) && !immd_i[0];
      end
      FMT_U: begin
        instr_o = {immd_i[31:12], rd_i, opcode_i};
        legal_o = (immd_i[11:0] == '0);
      end
      FMT_J: begin
        instr_o = {immd_i[20], immd_i[10:1], immd_i[11], immd_i[19:12],
                   rd_i, opcode_i};
        legal_o = in_range(immd_i, JIMM_MIN, JIMM_MAX) && !immd_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Load-session sequencer: encodes requests into RV32I words and streams them
// to instruction memory at consecutive addresses, dropping illegal requests.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     count,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_fmt,
  input  logic [6:0]           req_opcode,
  input  logic [4:0]           req_rd,
  input  logic [4:0]           req_rs1,
  input  logic [4:0]           req_rs2,
  input  logic [2:0]           req_func3,
  input  logic [6:0]           req_func7,
  input  logic [WORD_SIZE-1:0] req_immd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [CNT_W-1:0]       rem_q;
  logic                   out_valid_q;
  logic [ADDR_W-1:0]      out_addr_q;
  logic [WORD_SIZE-1:0]   out_instr_q;
  logic                   done_q;
  logic                   err_q;
  logic [CNT_W-1:0]       err_count_q;

  logic [WORD_SIZE-1:0]   packed_instr;
  logic                   packed_legal;
  logic                   accept;
  logic                   out_free;

  instr_pack u_pack (
    .fmt_i    (req_fmt),
    .opcode_i (req_opcode),
    .rd_i     (req_rd),
    .rs1_i    (req_rs1),
    .rs2_i    (req_rs2),
    .func3_i  (req_func3),
    .func7_i  (req_func7),
    .immd_i   (req_immd),
    .instr_o  (packed_instr),
    .legal_o  (packed_legal)
  );

  // Output register is free if empty or being drained this cycle.
  assign out_free  = !out_valid_q || out_ready;
  assign req_ready = (state_q == S_RUN) && out_free;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (accept) begin
        rem_q <= rem_q - 1'b1;
        if (packed_legal) begin
          out_valid_q <= 1'b1;
          out_addr_q  <= addr_q;
          out_instr_q <= packed_instr;
          addr_q      <= addr_q + 1'b1;
        end else begin
          err_q <= 1'b1;
          if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            rem_q       <= count;
            err_q       <= 1'b0;
            err_count_q <= '0;
            if (count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept && (rem_q == CNT_W'(1))) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_free) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_instr = out_instr_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed scoreboard bench for instr_encoder_loader.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  count;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [2:0]  req_func3;
  logic [6:0]  req_func7;
  logic [31:0] req_immd;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_addr;
  logic [31:0] out_instr;
  logic        busy, done, err;
  logic [9:0]  err_count;

  instr_encoder_loader #(.WORD_SIZE(32), .ADDR_W(10), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_func3(req_func3), .req_func7(req_func7),
    .req_immd(req_immd), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr), .busy(busy), .done(done),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  exp_addr;
  logic        any_valid;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: a transfer completes at the next edge when valid&ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
      if (out_valid && out_ready && !rst) begin
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_addr", 32'(out_addr), 32'(e.addr));
          check("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] instr);
    exp_t e;
    e.addr  = exp_addr;
    e.instr = instr;
    sb.push_back(e);
    exp_addr = exp_addr + 10'd1;
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    req_fmt = fmt; req_opcode = op; req_rd = rd; req_rs1 = rs1;
    req_rs2 = rs2; req_func3 = f3; req_func7 = f7; req_immd = imm;
    req_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic legal, input logic [31:0] instr);
    int w = 0;
    set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
    @(negedge clk);
    while (!req_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    if (legal) push_exp(instr);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic start_sess(input logic [9:0] b, input logic [9:0] c);
    @(posedge clk); #1;
    base_addr = b; count = c; start = 1'b1;
    exp_addr = b; any_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    @(negedge clk);
    while (!done && w < 40) begin
      w++;
      @(negedge clk);
    end
    check(tag, 32'(done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int unsigned c0, c1;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; req_valid = 1'b0;
    req_fmt = '0; req_opcode = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_func3 = '0; req_func7 = '0; req_immd = '0; out_ready = 1'b1;
    exp_addr = '0; any_valid = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single ADDI
    start_sess(10'h010, 10'd1);
    send(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,
         1'b1, 32'hFFF0_0093);
    wait_done("done_addi");
    check("err_addi", 32'(err), 32'd0);

    // Back-to-back S/B/J, one word per cycle
    start_sess(10'h010, 10'd3);
    c0 = cyc;
    send(FMT_S, OPCODE_STORE, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8,
         1'b1, 32'h0051_2423);
    send(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,
         1'b1, 32'hFE00_0EE3);
    send(FMT_J, OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
         1'b1, 32'h0010_00EF);
    c1 = cyc;
    check("b2b_cycles", c1 - c0, 32'd3);
    wait_done("done_b2b");

    // U, I-shift, R
    start_sess(10'h100, 10'd3);
    send(FMT_U, OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,
         1'b1, 32'h1234_52B7);
    send(FMT_I, OPCODE_OP_IMM, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7,
         1'b1, 32'h4072_5193);
    send(FMT_R, OPCODE_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF,
         1'b1, 32'h0020_81B3);
    wait_done("done_uir");
    check("err_uir", 32'(err), 32'd0);

    // Illegal requests: all dropped
    start_sess(10'h200, 10'd4);
    send(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, '0);
    send(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, '0);
    send(FMT_U, OPCODE_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 1'b0, '0);
    send(3'd7, OPCODE_OP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, '0);
    wait_done("done_illegal");
    check("err_illegal", 32'(err), 32'd1);
    check("err_count_illegal", 32'(err_count), 32'd4);
    check("addr_unchanged", 32'(out_addr), 32'h102);
    check("no_word_illegal", 32'(any_valid), 32'd0);

    // Back-pressure: pending word held while out_ready low
    start_sess(10'h040, 10'd2);
    check("err_cleared", 32'(err), 32'd0);
    out_ready = 1'b0;
    send(FMT_I, OPCODE_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,
         1'b1, 32'h0050_0113);
    set_req(FMT_I, OPCODE_OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    repeat (5) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_instr", out_instr, 32'h0050_0113);
      check("stall_addr", 32'(out_addr), 32'h040);
      check("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_accept", 32'(req_ready), 32'd1);
    push_exp(32'h0060_0193);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done("done_stall");

    // count == 0
    start_sess(10'h000, 10'd0);
    @(negedge clk);
    check("done_count0", 32'(done), 32'd1);
    @(negedge clk);
    check("idle_count0", 32'(busy), 32'd0);
    check("no_word_count0", 32'(any_valid), 32'd0);

    // Address wrap with boundary immediates
    start_sess(10'h3FF, 10'd2);
    send(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,
         1'b1, 32'h7FF0_0093);
    send(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,
         1'b1, 32'h7E00_0FE3);
    wait_done("done_wrap");
    check("err_wrap", 32'(err), 32'd0);

    // Reset mid-session discards the pending word
    start_sess(10'h050, 10'd3);
    out_ready = 1'b0;
    send(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,
         1'b1, 32'h0010_0093);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_idle", 32'(busy), 32'd0);
    check("postrst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
